// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: resolves jr > jump > branch > stall > +4 each cycle, with a RUN/HALT freeze and run statistics.
// A redirect in cycle N flushes IF/ID and ID/EX that same cycle and appears on pc_out in N+1; stall holds the PC.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  input  logic             halt,
  input  logic             go,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycles,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jump
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [CNT_W-1:0] cyc_nxt, br_nxt, jmp_nxt;
  logic             redirect;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cyc_nxt   = cnt_cycles;
    br_nxt    = cnt_branch;
    jmp_nxt   = cnt_jump;
    redirect  = 1'b0;
    case (state)
      RUN: begin
        cyc_nxt = cnt_cycles + CNT_W'(1);
        if (halt) begin
          state_nxt = HALT;
        end else if (jr) begin
          pc_nxt   = jr_target & ALIGN_MASK;
          jmp_nxt  = cnt_jump + CNT_W'(1);
          redirect = 1'b1;
        end else if (jump) begin
          pc_nxt   = jump_target & ALIGN_MASK;
          jmp_nxt  = cnt_jump + CNT_W'(1);
          redirect = 1'b1;
        end else if (branch) begin
          // Redirect beats stall: the stalled ID instruction is on the wrong path.
          pc_nxt   = branch_target & ALIGN_MASK;
          br_nxt   = cnt_branch + CNT_W'(1);
          redirect = 1'b1;
        end else if (!stall) begin
          pc_nxt = pc + 32'd4;
        end
      end
      HALT: begin
        if (go) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= RESET_PC & ALIGN_MASK;
      cnt_cycles <= '0;
      cnt_branch <= '0;
      cnt_jump   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      cnt_cycles <= cyc_nxt;
      cnt_branch <= br_nxt;
      cnt_jump   <= jmp_nxt;
    end
  end

  assign pc_out     = pc;
  assign pc_plus4   = pc + 32'd4;
  assign flush_ifid = redirect;
  assign flush_idex = redirect;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed vector table for pc_redirect_unit plus hand sequences for halt/reset corner cases.
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, jump, jr, halt, go;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc_out, pc_plus4;
  logic        flush_ifid, flush_idex, halted;
  logic [31:0] cnt_cycles, cnt_branch, cnt_jump;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch(branch), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .halt(halt), .go(go),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted),
    .cnt_cycles(cnt_cycles), .cnt_branch(cnt_branch), .cnt_jump(cnt_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, branch, jump, jr, halt, go;
    logic [31:0] bt, jt, jrt;
    logic [31:0] pc;
    logic        flush, hlt;
    logic [31:0] cyc, cb, cj;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                              logic r, logic [31:0] rt, logic h, logic g,
                              logic [31:0] pc, logic f, logic hl,
                              logic [31:0] cyc, logic [31:0] cb, logic [31:0] cj);
    vec_t v;
    v.stall = s; v.branch = b; v.bt = bt; v.jump = j; v.jt = jt; v.jr = r; v.jrt = rt;
    v.halt = h; v.go = g; v.pc = pc; v.flush = f; v.hlt = hl;
    v.cyc = cyc; v.cb = cb; v.cj = cj;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic f, input logic hl,
                           input logic [31:0] cyc, input logic [31:0] cb, input logic [31:0] cj);
    chk({tag, ".pc_out"},     pc_out, pc);
    chk({tag, ".pc_plus4"},   pc_plus4, pc + 32'd4);
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, f});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, f});
    chk({tag, ".halted"},     {31'd0, halted}, {31'd0, hl});
    chk({tag, ".cnt_cycles"}, cnt_cycles, cyc);
    chk({tag, ".cnt_branch"}, cnt_branch, cb);
    chk({tag, ".cnt_jump"},   cnt_jump, cj);
  endtask

  task automatic idle_inputs();
    stall = 0; branch = 0; jump = 0; jr = 0; halt = 0; go = 0;
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
  endtask

  initial begin
    //           st br bt            jp jt            jr jrt           ht go  pc            fl hl cyc  cb cj
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h4,        0, 0, 1,  0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h8,        0, 0, 2,  0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'hC,        0, 0, 3,  0, 0);
    vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h10,       0, 0, 4,  0, 0);
    vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h10,       0, 0, 5,  0, 0);
    vecs[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h10,       0, 0, 6,  0, 0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h10,       0, 0, 7,  0, 0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h14,       0, 0, 8,  0, 0);
    vecs[9]  = mk(0, 0, 32'h0,        1, 32'h23,       0, 32'h0,        0, 0, 32'h18,       1, 0, 9,  0, 0);
    vecs[10] = mk(0, 1, 32'h40,       0, 32'h0,        0, 32'h0,        0, 0, 32'h20,       1, 0, 10, 0, 1);
    vecs[11] = mk(1, 1, 32'h80,       0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       1, 0, 11, 1, 1);
    vecs[12] = mk(0, 1, 32'h200,      0, 32'h0,        1, 32'h100,      0, 0, 32'h80,       1, 0, 12, 2, 1);
    vecs[13] = mk(0, 1, 32'h300,      0, 32'h0,        0, 32'h0,        1, 0, 32'h100,      0, 0, 13, 2, 2);
    vecs[14] = mk(1, 1, 32'h300,      1, 32'h400,      1, 32'h500,      0, 0, 32'h100,      0, 1, 14, 2, 2);
    vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h100,      0, 1, 14, 2, 2);
    vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 32'h100,      0, 1, 14, 2, 2);
    vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 32'h100,      0, 0, 14, 2, 2);
    vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFE, 0, 0, 32'h104,     1, 0, 15, 2, 2);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'hFFFF_FFFC, 0, 0, 16, 2, 3);
    vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 17, 2, 3);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_state("reset", 32'h0, 1'b0, 1'b0, 0, 0, 0);

    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stall; branch = vecs[i].branch; branch_target = vecs[i].bt;
      jump = vecs[i].jump; jump_target = vecs[i].jt; jr = vecs[i].jr; jr_target = vecs[i].jrt;
      halt = vecs[i].halt; go = vecs[i].go;
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].flush, vecs[i].hlt,
                vecs[i].cyc, vecs[i].cb, vecs[i].cj);
      @(negedge clk);
    end

    // Wrap continues into +4 after the last vector.
    idle_inputs();
    #1;
    chk_state("post_wrap", 32'h4, 1'b0, 1'b0, 18, 2, 3);

    // Enter HALT, then reset while halted.
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    #1;
    chk_state("halt_entry", 32'h4, 1'b0, 1'b1, 19, 2, 3);
    rst_n = 1'b0;
    go = 1'b0;
    @(negedge clk);
    #1;
    chk_state("reset_in_halt", 32'h0, 1'b0, 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_state("after_reset_run", 32'h4, 1'b0, 1'b0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
